wb_spi_bridge: RTL and testbench
================================

# wb_spi_bridge

Wishbone-slave SPI master that lets the management SoC command the on-chip rapcore motor controller through its existing SPI port. It sits directly upstream of rapcore inside the rapcores user project: it drives rapcore's SCK/CS/COPI inputs and captures its CIPO output. The SoC loads a 64-bit command word, starts a transfer, polls or waits for completion, and reads back the 64-bit reply.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode uses wbs_adr_i[31:8] == BASE_ADDR[31:8].
- WORD_BITS, 64, SPI transfer length in bits; fixed at 64 for rapcore.
- DIV_RESET, 8'd3, reset value of CTRL.clkdiv.

Ports:
- wb_clk_i  in  1  system clock; the block's only clock.
- resetn  in  1  synchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic handshake.
- wbs_sel_i  in  4  byte lanes; a write updates only selected bytes.
- wbs_adr_i  in  32  byte address; offset = wbs_adr_i[7:0].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o = 1, else 0.
- spi_sck_o  out  1  SPI clock, mode 0 (idle low).
- spi_cs_o  out  1  chip select, active low.
- spi_copi_o  out  1  serial data to rapcore, MSB first.
- spi_cipo_i  in  1  serial data from rapcore.
- busy_o  out  1  transfer in progress.
- done_irq_o  out  1  level; equals STATUS.done.

## Operation
- Registers (offset): 0x00 CTRL: [7:0] clkdiv, [8] start (write-1, reads 0), [9] keep_cs. 0x04 STATUS: [0] busy (RO), [1] done (sticky, write-1-to-clear). 0x08 TX_LO, 0x0C TX_HI, 0x10 RX_LO (RO), 0x14 RX_HI (RO). Other offsets in range: read 0, writes ignored, still acked. Addresses outside BASE_ADDR: no ack.
- Reset values: all registers 0 except clkdiv = DIV_RESET; spi_sck_o = 0, spi_cs_o = 1, spi_copi_o = 0, wbs_ack_o = 0, busy_o = 0, done_irq_o = 0.
- Wishbone: access accepted when cyc & stb & decode & !ack; ack driven the following cycle for one cycle; register write takes effect on the accepting edge.
- Writing start = 1 while idle loads shift register from {TX_HI, TX_LO}, clears done, enters SETUP. While busy: start ignored, writes to TX_*/clkdiv/keep_cs ignored, still acked.
- Half-period h = clkdiv + 1 cycles, timed by an 8-bit down-counter.
- FSM: IDLE -> SETUP (CS low, COPI = bit 63, one h) -> SHIFT (2*WORD_BITS half-periods; on each rising SCK sample spi_cipo_i into shift LSB; on each falling SCK shift left, present next MSB) -> HOLD (SCK low, one h) -> IDLE. On HOLD exit: RX_HI/RX_LO <= captured word, done <= 1, busy <= 0, CS <= 1 unless keep_cs = 1.
- keep_cs = 1: CS stays low after completion so consecutive words form one frame; writing keep_cs = 0 while idle releases CS on the next edge.
- Simultaneous completion and done write-1-to-clear: set wins.
- resetn low mid-transfer: next edge returns to reset values; RX unchanged from before (reset to 0).

## Timing
- Start write accepted at edge E: busy_o = 1 and spi_cs_o = 0 from E+1.
- Total busy time = (2*WORD_BITS + 2) * h cycles; clkdiv = 0 -> 130 cycles, clkdiv = 3 -> 520 cycles.
- First rising SCK at E+1+h; COPI stable h cycles before each rising edge.
- done/RX updated on the same edge busy_o falls; a STATUS read acked in that cycle already shows done = 1.
- Register read latency: 1 cycle (ack cycle).

## Structure
- Package rapcores_pkg: register offset localparams, CTRL/STATUS bit indices, FSM state enum (IDLE, SETUP, SHIFT, HOLD).
- Sub-module spi_shift_engine: half-period counter, FSM, shift register, SCK/CS/COPI generation; top holds Wishbone decode and register file.

## Test plan
- Reset: after resetn low 1 cycle, read CTRL -> 0x0000_0003, STATUS -> 0; cs = 1, sck = 0.
- Loopback (COPI tied to CIPO), TX = 0xDEADBEEF_01234567, clkdiv = 0, start -> busy 130 cycles, RX_HI = 0xDEADBEEF, RX_LO = 0x01234567, done = 1.
- rapcore slave model returning 0xA5A5_0000_FFFF_0001 with clkdiv = 3 -> 64 rising SCK edges, 8-cycle SCK period, RX matches.
- Write TX_LO = 0x11111111 and start during a transfer -> acked, TX_LO and ongoing transfer unaffected; only one frame sent.
- keep_cs = 1, two back-to-back starts -> CS low continuously across 128 bits; clear keep_cs -> CS high next cycle.
- resetn asserted at cycle 40 of a transfer -> next edge CS = 1, SCK = 0, busy = 0, RX = 0; sel = 4'b0001 write 0xFF to TX_HI -> only byte 0 changes.

Source files
------------

// File: rtl/rapcores_pkg.sv
// Shared register map, control/status bit positions and SPI FSM states for the rapcore bridge.
// Latency: n/a (declarations and a pure byte-merge helper only).
// Backpressure: n/a.
package rapcores_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_TX_LO  = 8'h08;
  localparam logic [7:0] OFF_TX_HI  = 8'h0C;
  localparam logic [7:0] OFF_RX_LO  = 8'h10;
  localparam logic [7:0] OFF_RX_HI  = 8'h14;

  localparam int CTRL_START   = 8;
  localparam int CTRL_KEEP_CS = 9;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  // Replace only the byte lanes selected by sel, keep the others.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master engine: half-period timer, frame FSM, shift register, SCK/CS/COPI drive.
// Latency: busy/CS from the cycle after start; frame lasts (2*WORD_BITS+2)*(clkdiv+1) cycles.
// Backpressure: none; start is only honoured while idle, caller must gate it.
module spi_shift_engine
  import rapcores_pkg::*;
#(
  parameter int WORD_BITS = 64
) (
  input  logic                 wb_clk_i,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           clkdiv,
  input  logic                 keep_cs,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 cipo,
  output logic                 sck,
  output logic                 cs,
  output logic                 copi,
  output logic                 busy,
  output logic                 finish,
  output logic [WORD_BITS-1:0] rx_word
);

  localparam int HALF_W = $clog2(2 * WORD_BITS);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * WORD_BITS - 1);

  spi_state_t           state;
  logic [7:0]           cnt;
  logic [HALF_W-1:0]    half;
  logic [WORD_BITS-1:0] shreg;

  // Completion is the last cycle of HOLD; the register file captures RX on this edge.
  assign finish  = (state == HOLD) && (cnt == 8'd0);
  assign rx_word = shreg;

  // Frame sequencer. Receive bits are shifted in on the rising SCK edge, which also
  // moves the next transmit bit to the MSB; the falling edge only presents it on COPI.
  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 8'd0;
      half  <= '0;
      shreg <= '0;
      sck   <= 1'b0;
      cs    <= 1'b1;
      copi  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETUP;
            cnt   <= clkdiv;
            shreg <= tx_word;
            cs    <= 1'b0;
            copi  <= tx_word[WORD_BITS-1];
            busy  <= 1'b1;
          end else if (!keep_cs) begin
            cs <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= SHIFT;
            cnt   <= clkdiv;
            half  <= '0;
            sck   <= 1'b1;
            shreg <= {shreg[WORD_BITS-2:0], cipo};
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (cnt == 8'd0) begin
            cnt  <= clkdiv;
            half <= half + 1'b1;
            if (half == LAST_HALF) begin
              state <= HOLD;
            end else if (sck) begin
              sck  <= 1'b0;
              copi <= shreg[WORD_BITS-1];
            end else begin
              sck   <= 1'b1;
              shreg <= {shreg[WORD_BITS-2:0], cipo};
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            cs    <= !keep_cs;
            copi  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_spi_bridge.sv
// Wishbone slave register file that drives a 64-bit SPI master toward rapcore.
// Latency: every accepted access is acked exactly one cycle later; reads return in the ack cycle.
// Backpressure: none; writes that would disturb a running frame are acked and dropped.
module wb_spi_bridge
  import rapcores_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WORD_BITS = 64,
  parameter logic [7:0]  DIV_RESET = 8'd3
) (
  input  logic        wb_clk_i,
  input  logic        resetn,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o,
  output logic        spi_copi_o,
  input  logic        spi_cipo_i,
  output logic        busy_o,
  output logic        done_irq_o
);

  logic [7:0]  clkdiv;
  logic        keep_cs;
  logic        done;
  logic [31:0] tx_lo, tx_hi, rx_lo, rx_hi;
  logic [7:0]  rd_off;
  logic        rd_we;
  logic [31:0] rdata;

  logic        hit, acc, wr, ctrl_wr, status_wr, start, busy, finish;
  logic [7:0]  off;
  logic [7:0]  clkdiv_nxt;
  logic        keep_cs_nxt;
  logic [WORD_BITS-1:0] rx_word;

  assign off       = wbs_adr_i[7:0];
  assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc       = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
  assign wr        = acc && wbs_we_i;
  assign ctrl_wr   = wr && (off == OFF_CTRL);
  assign status_wr = wr && (off == OFF_STATUS);
  assign start     = ctrl_wr && wbs_sel_i[1] && wbs_dat_i[CTRL_START] && !busy;

  // The engine sees the CTRL values that land on this edge, so a write that sets
  // clkdiv together with start (or clears keep_cs) takes effect immediately.
  assign clkdiv_nxt  = (ctrl_wr && wbs_sel_i[0] && !busy) ? wbs_dat_i[7:0] : clkdiv;
  assign keep_cs_nxt = (ctrl_wr && wbs_sel_i[1] && !busy) ? wbs_dat_i[CTRL_KEEP_CS] : keep_cs;

  spi_shift_engine #(
    .WORD_BITS(WORD_BITS)
  ) u_engine (
    .wb_clk_i (wb_clk_i),
    .resetn   (resetn),
    .start    (start),
    .clkdiv   (clkdiv_nxt),
    .keep_cs  (keep_cs_nxt),
    .tx_word  ({tx_hi, tx_lo}),
    .cipo     (spi_cipo_i),
    .sck      (spi_sck_o),
    .cs       (spi_cs_o),
    .copi     (spi_copi_o),
    .busy     (busy),
    .finish   (finish),
    .rx_word  (rx_word)
  );

  assign busy_o     = busy;
  assign done_irq_o = done;

  // Register file, Wishbone ack and sticky done (completion beats a same-cycle clear).
  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      clkdiv    <= DIV_RESET;
      keep_cs   <= 1'b0;
      done      <= 1'b0;
      tx_lo     <= '0;
      tx_hi     <= '0;
      rx_lo     <= '0;
      rx_hi     <= '0;
      wbs_ack_o <= 1'b0;
      rd_off    <= '0;
      rd_we     <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) begin
        rd_off <= off;
        rd_we  <= wbs_we_i;
      end
      clkdiv  <= clkdiv_nxt;
      keep_cs <= keep_cs_nxt;
      if (wr && !busy && off == OFF_TX_LO) tx_lo <= merge_bytes(tx_lo, wbs_dat_i, wbs_sel_i);
      if (wr && !busy && off == OFF_TX_HI) tx_hi <= merge_bytes(tx_hi, wbs_dat_i, wbs_sel_i);
      if (finish) begin
        done  <= 1'b1;
        rx_hi <= rx_word[63:32];
        rx_lo <= rx_word[31:0];
      end else if (start) begin
        done <= 1'b0;
      end else if (status_wr && wbs_sel_i[0] && wbs_dat_i[STAT_DONE]) begin
        done <= 1'b0;
      end
    end
  end

  // Read mux uses live register values so a read acked on the completion cycle sees done.
  always_comb begin
    rdata = '0;
    case (rd_off)
      OFF_CTRL:   rdata = {22'd0, keep_cs, 1'b0, clkdiv};
      OFF_STATUS: rdata = {30'd0, done, busy};
      OFF_TX_LO:  rdata = tx_lo;
      OFF_TX_HI:  rdata = tx_hi;
      OFF_RX_LO:  rdata = rx_lo;
      OFF_RX_HI:  rdata = rx_hi;
      default:    rdata = '0;
    endcase
  end

  assign wbs_dat_o = (wbs_ack_o && !rd_we) ? rdata : 32'd0;

endmodule

// File: tb/tb_wb_spi_bridge.sv
module tb_wb_spi_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_TXLO = 8'h08, A_TXHI = 8'h0C,
                         A_RXLO = 8'h10, A_RXHI = 8'h14;

  logic        wb_clk_i = 1'b0;
  logic        resetn = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        spi_sck_o, spi_cs_o, spi_copi_o, spi_cipo_i, busy_o, done_irq_o;

  wb_spi_bridge dut (
    .wb_clk_i(wb_clk_i), .resetn(resetn),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .spi_sck_o(spi_sck_o), .spi_cs_o(spi_cs_o), .spi_copi_o(spi_copi_o),
    .spi_cipo_i(spi_cipo_i), .busy_o(busy_o), .done_irq_o(done_irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_chk = 0, n_fail = 0;
  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // ---------------- slave side: loopback or rapcore reply model ----------------
  bit          loop_mode = 1'b1;
  logic [63:0] slave_word = 64'hA5A5_0000_FFFF_0001;
  int          sidx = 0;
  logic        slave_bit;
  always @(negedge spi_sck_o) if (spi_cs_o === 1'b0) sidx <= sidx + 1;
  always @(posedge spi_cs_o) sidx <= 0;
  assign slave_bit  = (sidx < 64) ? slave_word[63 - sidx] : 1'b0;
  assign spi_cipo_i = loop_mode ? spi_copi_o : slave_bit;

  // ---------------- monitors ----------------
  int  rise_cnt = 0, busy_cnt = 0, cs_high_cnt = 0, cs_fall = 0;
  bit  mon_cs = 1'b0;
  time last_rise = 0, sck_period = 0;
  always @(posedge spi_sck_o) begin
    rise_cnt++;
    if (rise_cnt == 2) sck_period = (($time - last_rise) / 10);
    last_rise = $time;
  end
  always @(negedge spi_cs_o) cs_fall++;
  always @(negedge wb_clk_i) begin
    if (busy_o === 1'b1) busy_cnt++;
    if (mon_cs && spi_cs_o !== 1'b0) cs_high_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is described by its start edge and half-period; everything observable
  // is a function of the cycle index t counted from that edge.
  bit          chk_on = 1'b0;
  bit          m_act = 1'b0, m_done = 1'b0, m_keep = 1'b0, m_held = 1'b0;
  int          m_st = 0, m_h = 1;
  logic [7:0]  m_div = 8'd3;
  logic [31:0] m_txlo = 32'd0, m_txhi = 32'd0;
  logic [63:0] m_tx = 64'd0, m_rx = 64'd0;

  function automatic bit busy_at(int t);
    return m_act && t >= 1 && t <= 130 * m_h;
  endfunction
  function automatic bit done_at(int t);
    return m_done || (m_act && t > 130 * m_h);
  endfunction
  function automatic logic [31:0] mrg(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[i/8] ? n[i] : o[i];
    return r;
  endfunction

  always @(negedge wb_clk_i) begin : cmp
    int t, u, j;
    logic eb, es, ec, eo;
    bit ochk;
    if (chk_on) begin
      t = cyc_cnt - m_st;
      if (m_act && t > 130 * m_h) begin
        m_act  = 1'b0;
        m_done = 1'b1;
        m_rx   = loop_mode ? m_tx : slave_word;
        m_held = m_keep;
      end
      eb = 1'b0; es = 1'b0; ec = !m_held; eo = 1'b0; ochk = 1'b0;
      if (m_act && t >= 1) begin
        eb = 1'b1; ec = 1'b0;
        u = t - 1 - m_h;
        if (u < 0) begin
          eo = m_tx[63]; ochk = 1'b1;
        end else if (u < 128 * m_h) begin
          j  = u / m_h;
          es = (j % 2 == 0);
          if (j < 127) begin eo = m_tx[63 - (j + 1) / 2]; ochk = 1'b1; end
        end
      end
      chk("busy_o", busy_o, eb);
      chk("spi_cs_o", spi_cs_o, ec);
      chk("spi_sck_o", spi_sck_o, es);
      chk("done_irq_o", done_irq_o, m_done);
      if (ochk) chk("spi_copi_o", spi_copi_o, eo);
    end
  end

  // ---------------- Wishbone tasks ----------------
  logic cs_at_ack;

  task automatic wb_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    int acc;
    bit bsy;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = sel;
    wbs_adr_i = BASE | {24'd0, off}; wbs_dat_i = dat;
    @(posedge wb_clk_i);
    acc = cyc_cnt;
    bsy = busy_at(acc - m_st);
    if (!bsy) begin
      if (off == A_CTRL) begin
        if (sel[0]) m_div = dat[7:0];
        if (sel[1]) m_keep = dat[9];
        if (!m_keep) m_held = 1'b0;
        if (sel[1] && dat[8]) begin
          m_act = 1'b1; m_st = acc; m_h = int'(m_div) + 1;
          m_tx = {m_txhi, m_txlo}; m_done = 1'b0;
        end
      end
      if (off == A_TXLO) m_txlo = mrg(m_txlo, dat, sel);
      if (off == A_TXHI) m_txhi = mrg(m_txhi, dat, sel);
    end
    if (off == A_STAT && sel[0] && dat[1]) m_done = 1'b0;
    #1;
    chk("wr_ack", wbs_ack_o, 1'b1);
    cs_at_ack = spi_cs_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    @(posedge wb_clk_i); #1;
    chk("wr_ack_drop", wbs_ack_o, 1'b0);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] dat, output int acc);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF;
    wbs_adr_i = BASE | {24'd0, off};
    @(posedge wb_clk_i);
    acc = cyc_cnt;
    #1;
    chk("rd_ack", wbs_ack_o, 1'b1);
    dat = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge wb_clk_i); #1;
    chk("rd_dat_idle", wbs_dat_o, 32'd0);
  endtask

  // Checks against a hand-computed literal and against the model's register view.
  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] lit);
    logic [31:0] d, m;
    int acc;
    wb_read(off, d, acc);
    case (off)
      A_CTRL:  m = {22'd0, m_keep, 1'b0, m_div};
      A_TXLO:  m = m_txlo;
      A_TXHI:  m = m_txhi;
      A_RXLO:  m = m_rx[31:0];
      A_RXHI:  m = m_rx[63:32];
      A_STAT:  m = {30'd0, done_at(acc + 1 - m_st), busy_at(acc + 1 - m_st)};
      default: m = 32'd0;
    endcase
    chk(name, d, lit);
    chk({name, "_model"}, d, m);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < max_cyc) begin
      @(posedge wb_clk_i); #1; n++;
    end
    chk("idle_timeout", busy_o, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    resetn = 0;
    @(posedge wb_clk_i); #1;
    chk("rst_cs", spi_cs_o, 1'b1);
    chk("rst_sck", spi_sck_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ack", wbs_ack_o, 1'b0);
    resetn = 1;
    chk_on = 1;
    rd_chk("rst_ctrl", A_CTRL, 32'h0000_0003);
    rd_chk("rst_status", A_STAT, 32'h0);

    // ---- unmapped offset and foreign address ----
    wb_write(8'h18, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped_rd", 8'h18, 32'h0);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      chk("foreign_no_ack", wbs_ack_o, 1'b0);
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;

    // ---- loopback, clkdiv 0 ----
    loop_mode = 1;
    wb_write(A_TXLO, 32'h0123_4567, 4'hF);
    wb_write(A_TXHI, 32'hDEAD_BEEF, 4'hF);
    busy_cnt = 0;
    wb_write(A_CTRL, 32'h0000_0100, 4'h3);
    wait_idle(2000);
    chk("lb_busy_cycles", busy_cnt, 130);
    rd_chk("lb_rx_hi", A_RXHI, 32'hDEAD_BEEF);
    rd_chk("lb_rx_lo", A_RXLO, 32'h0123_4567);
    rd_chk("lb_status", A_STAT, 32'h2);
    wb_write(A_STAT, 32'h2, 4'h1);
    rd_chk("done_w1c", A_STAT, 32'h0);

    // ---- rapcore slave model, clkdiv 3, with writes during the frame ----
    loop_mode = 0;
    wb_write(A_TXLO, 32'hC3C3_C3C3, 4'hF);
    wb_write(A_TXHI, 32'h0F0F_0F0F, 4'hF);
    busy_cnt = 0; rise_cnt = 0; cs_fall = 0;
    wb_write(A_CTRL, 32'h0000_0103, 4'h3);
    wb_write(A_TXLO, 32'h1111_1111, 4'hF);
    wb_write(A_CTRL, 32'h0000_0100, 4'hF);
    rd_chk("busy_txlo_kept", A_TXLO, 32'hC3C3_C3C3);
    rd_chk("busy_ctrl_kept", A_CTRL, 32'h0000_0003);
    wait_idle(5000);
    chk("sl_rises", rise_cnt, 64);
    chk("sl_sck_period", sck_period, 8);
    chk("sl_busy_cycles", busy_cnt, 520);
    chk("sl_one_frame", cs_fall, 1);
    rd_chk("sl_rx_hi", A_RXHI, 32'hA5A5_0000);
    rd_chk("sl_rx_lo", A_RXLO, 32'hFFFF_0001);

    // ---- keep_cs: two back-to-back frames under one CS ----
    loop_mode = 1;
    wb_write(A_TXLO, 32'h89AB_CDEF, 4'hF);
    wb_write(A_TXHI, 32'h0123_4567, 4'hF);
    wb_write(A_CTRL, 32'h0000_0200, 4'h3);
    rise_cnt = 0; cs_high_cnt = 0;
    wb_write(A_CTRL, 32'h0000_0300, 4'h3);
    mon_cs = 1;
    wait_idle(2000);
    wb_write(A_CTRL, 32'h0000_0300, 4'h3);
    wait_idle(2000);
    mon_cs = 0;
    chk("keep_cs_low", cs_high_cnt, 0);
    chk("keep_rises", rise_cnt, 128);
    rd_chk("keep_rx_lo", A_RXLO, 32'h89AB_CDEF);
    wb_write(A_CTRL, 32'h0000_0000, 4'h3);
    chk("keep_release", cs_at_ack, 1'b1);

    // ---- reset in the middle of a frame ----
    wb_write(A_CTRL, 32'h0000_0100, 4'h3);
    repeat (38) @(posedge wb_clk_i);
    #1;
    chk_on = 0;
    resetn = 0;
    @(posedge wb_clk_i); #1;
    chk("mid_rst_cs", spi_cs_o, 1'b1);
    chk("mid_rst_sck", spi_sck_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_irq_o, 1'b0);
    resetn = 1;
    m_act = 0; m_done = 0; m_keep = 0; m_held = 0; m_div = 8'd3;
    m_txlo = 0; m_txhi = 0; m_tx = 0; m_rx = 0;
    chk_on = 1;
    rd_chk("mid_rst_rx_hi", A_RXHI, 32'h0);
    rd_chk("mid_rst_rx_lo", A_RXLO, 32'h0);
    rd_chk("mid_rst_ctrl", A_CTRL, 32'h0000_0003);

    // ---- byte-lane write ----
    wb_write(A_TXHI, 32'h1234_5678, 4'hF);
    wb_write(A_TXHI, 32'h0000_00FF, 4'h1);
    rd_chk("sel_byte0", A_TXHI, 32'h1234_56FF);
    rd_chk("sel_txlo", A_TXLO, 32'h0);

    @(negedge wb_clk_i);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
